// File: rtl/jtag_chain_router_pkg.sv
// Shared definitions for the JTAG chain router: device count, special link
// indices, FSM state encoding and error codes.
package jtag_chain_router_pkg;

  localparam int NUM_DEV      = 7;
  localparam int NUM_DEV_BITS = 3;

  localparam int DEF_N_NODE = NUM_DEV + 1;
  localparam int DEF_IW     = NUM_DEV_BITS + 1;

  // Reserved link values that sit just above the last real device index.
  localparam int FIRST_INDEX = NUM_DEV + 1;
  localparam int LAST_INDEX  = NUM_DEV + 2;
  localparam int NULL_INDEX  = NUM_DEV + 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_ROUTE,
    ST_FAULT
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_LINK    = 3'd2;
  localparam logic [2:0] ERR_ENDS    = 3'd3;
  localparam logic [2:0] ERR_EMPTY   = 3'd4;
  localparam logic [2:0] ERR_CHANGED = 3'd5;

endpackage

// File: rtl/jtag_chain_router_mux.sv
// Combinational daisy-chain data path: routes master TDI through the active
// devices in link order and returns the last device's TDO to the master.
module jtag_route_mux
  import jtag_chain_router_pkg::*;
#(
  parameter int N_NODE = DEF_N_NODE,
  parameter int IW     = DEF_IW,
  parameter int DW     = $clog2(N_NODE)
) (
  input  logic                 route_valid,
  input  logic [N_NODE-1:0]    act,
  input  logic [N_NODE*IW-1:0] tdi_tab_flat,
  input  logic [DW-1:0]        last_idx,
  input  logic                 m_tdi,
  input  logic [N_NODE-1:0]    dev_tdo,
  output logic [N_NODE-1:0]    dev_tdi,
  output logic                 m_tdo
);

  localparam logic [IW-1:0] FIRST_I = IW'(FIRST_INDEX);

  logic [IW-1:0] tdi;

  always_comb begin
    // NOTE: every output gets its safe default first so no path infers a latch.
    dev_tdi = '1;
    m_tdo   = 1'b1;
    tdi     = '0;
    if (route_valid) begin
      for (int i = 0; i < N_NODE; i++) begin
        tdi = tdi_tab_flat[i*IW +: IW];
        if (tdi == FIRST_I) begin
          dev_tdi[i] = m_tdi;
        end else if (act[i]) begin
          dev_tdi[i] = dev_tdo[tdi[DW-1:0]];
        end
      end
      m_tdo = dev_tdo[last_idx];
    end
  end

endmodule

// File: rtl/jtag_chain_router.sv
// Waits for all per-node link searches, checks the TDI/TDO link tables one
// node per cycle, then drives the daisy-chain mux while the chain stays put.
module jtag_chain_router
  import jtag_chain_router_pkg::*;
#(
  parameter int N_NODE  = DEF_N_NODE,
  parameter int IW      = DEF_IW,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enb,
  input  logic [N_NODE-1:0]    active_chains,
  input  logic [N_NODE-1:0]    node_done,
  input  logic [N_NODE*IW-1:0] tdi_index_flat,
  input  logic [N_NODE*IW-1:0] tdo_index_flat,
  input  logic                 m_tdi,
  output logic                 m_tdo,
  input  logic [N_NODE-1:0]    dev_tdo,
  output logic [N_NODE-1:0]    dev_tdi,
  output logic                 route_valid,
  output logic                 route_error,
  output logic [2:0]           err_code,
  output logic [IW:0]          chain_len,
  output logic [IW-1:0]        first_idx,
  output logic [IW-1:0]        last_idx
);

  localparam int DW = $clog2(N_NODE);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW-1:0] FIRST_I  = IW'(FIRST_INDEX);
  localparam logic [IW-1:0] LAST_I   = IW'(LAST_INDEX);
  localparam logic [IW-1:0] NULL_I   = IW'(NULL_INDEX);
  localparam logic [IW-1:0] N_NODE_I = IW'(N_NODE);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [N_NODE-1:0] act_q, act_d;
  logic [IW-1:0]     tdi_tab_q [N_NODE];
  logic [IW-1:0]     tdi_tab_d [N_NODE];
  logic [IW-1:0]     tdo_tab_q [N_NODE];
  logic [IW-1:0]     tdo_tab_d [N_NODE];
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW:0]       chain_len_q, chain_len_d;
  logic [IW-1:0]     first_idx_q, first_idx_d;
  logic [IW-1:0]     last_idx_q, last_idx_d;
  logic [1:0]        first_cnt_q, first_cnt_d;
  logic [1:0]        last_cnt_q, last_cnt_d;
  logic              link_err_q, link_err_d;
  logic [2:0]        err_q, err_d;

  // Node currently under check and its link consistency.
  logic [DW-1:0] node;
  logic [IW-1:0] cur_tdi, cur_tdo;
  logic          cur_act, tdi_ok, tdo_ok, node_link_err;

  always_comb begin
    node    = idx_q[DW-1:0];
    cur_tdi = tdi_tab_q[node];
    cur_tdo = tdo_tab_q[node];
    cur_act = act_q[node];
    // tdi < idx keeps the back-link inside the table; tdo needs an explicit bound.
    tdi_ok  = (cur_tdi < idx_q) && act_q[cur_tdi[DW-1:0]] &&
              (tdo_tab_q[cur_tdi[DW-1:0]] == idx_q);
    tdo_ok  = (cur_tdo > idx_q) && (cur_tdo < N_NODE_I) &&
              act_q[cur_tdo[DW-1:0]] && (tdi_tab_q[cur_tdo[DW-1:0]] == idx_q);
    if (cur_act) begin
      node_link_err = ((cur_tdi != FIRST_I) && !tdi_ok) ||
                      ((cur_tdo != LAST_I) && !tdo_ok);
    end else begin
      node_link_err = (cur_tdi != NULL_I) || (cur_tdo != NULL_I);
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    act_d       = act_q;
    tdi_tab_d   = tdi_tab_q;
    tdo_tab_d   = tdo_tab_q;
    idx_d       = idx_q;
    chain_len_d = chain_len_q;
    first_idx_d = first_idx_q;
    last_idx_d  = last_idx_q;
    first_cnt_d = first_cnt_q;
    last_cnt_d  = last_cnt_q;
    link_err_d  = link_err_q;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enb) begin
          state_d = ST_WAIT;
          timer_d = TW'(TIMEOUT - 1);
        end
      end

      ST_WAIT: begin
        if (!enb) begin
          state_d = ST_IDLE;
        end else if (&node_done) begin
          state_d = ST_CHECK;
          act_d   = active_chains;
          for (int i = 0; i < N_NODE; i++) begin
            tdi_tab_d[i] = tdi_index_flat[i*IW +: IW];
            tdo_tab_d[i] = tdo_index_flat[i*IW +: IW];
          end
          idx_d       = '0;
          chain_len_d = '0;
          first_idx_d = '0;
          last_idx_d  = '0;
          first_cnt_d = '0;
          last_cnt_d  = '0;
          link_err_d  = 1'b0;
        end else if (timer_q == '0) begin
          state_d = ST_FAULT;
          err_d   = ERR_TIMEOUT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_CHECK: begin
        if (!enb) begin
          state_d = ST_IDLE;
        end else if (idx_q != N_NODE_I) begin
          idx_d = idx_q + IW'(1);
          if (node_link_err) link_err_d = 1'b1;
          if (cur_act) begin
            chain_len_d = chain_len_q + (IW+1)'(1);
            if (cur_tdi == FIRST_I) begin
              first_idx_d = idx_q;
              first_cnt_d = (first_cnt_q == 2'd2) ? 2'd2 : first_cnt_q + 2'd1;
            end
            if (cur_tdo == LAST_I) begin
              last_idx_d = idx_q;
              last_cnt_d = (last_cnt_q == 2'd2) ? 2'd2 : last_cnt_q + 2'd1;
            end
          end
        end else begin
          // Commit cycle: every node has been folded into the sticky results.
          if (link_err_q) begin
            state_d = ST_FAULT;
            err_d   = ERR_LINK;
          end else if (chain_len_q == '0) begin
            state_d = ST_FAULT;
            err_d   = ERR_EMPTY;
          end else if (first_cnt_q != 2'd1 || last_cnt_q != 2'd1) begin
            state_d = ST_FAULT;
            err_d   = ERR_ENDS;
          end else begin
            state_d = ST_ROUTE;
          end
        end
      end

      ST_ROUTE: begin
        if (!enb) begin
          state_d = ST_IDLE;
        end else if (active_chains != act_q) begin
          state_d = ST_FAULT;
          err_d   = ERR_CHANGED;
        end
      end

      ST_FAULT: begin
        if (!enb) begin
          state_d = ST_IDLE;
          err_d   = ERR_NONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      act_q       <= '0;
      idx_q       <= '0;
      chain_len_q <= '0;
      first_idx_q <= '0;
      last_idx_q  <= '0;
      first_cnt_q <= '0;
      last_cnt_q  <= '0;
      link_err_q  <= 1'b0;
      err_q       <= ERR_NONE;
      // NOTE: the link tables are reset to NULL so no stale link survives reset.
      for (int i = 0; i < N_NODE; i++) begin
        tdi_tab_q[i] <= NULL_I;
        tdo_tab_q[i] <= NULL_I;
      end
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      act_q       <= act_d;
      idx_q       <= idx_d;
      chain_len_q <= chain_len_d;
      first_idx_q <= first_idx_d;
      last_idx_q  <= last_idx_d;
      first_cnt_q <= first_cnt_d;
      last_cnt_q  <= last_cnt_d;
      link_err_q  <= link_err_d;
      err_q       <= err_d;
      tdi_tab_q   <= tdi_tab_d;
      tdo_tab_q   <= tdo_tab_d;
    end
  end

  assign route_valid = (state_q == ST_ROUTE);
  assign route_error = (state_q == ST_FAULT);
  assign err_code    = err_q;
  assign chain_len   = chain_len_q;
  assign first_idx   = first_idx_q;
  assign last_idx    = last_idx_q;

  logic [N_NODE*IW-1:0] tdi_tab_flat;

  always_comb begin
    tdi_tab_flat = '0;
    for (int i = 0; i < N_NODE; i++) tdi_tab_flat[i*IW +: IW] = tdi_tab_q[i];
  end

  jtag_route_mux #(
    .N_NODE (N_NODE),
    .IW     (IW),
    .DW     (DW)
  ) u_mux (
    .route_valid  (route_valid),
    .act          (act_q),
    .tdi_tab_flat (tdi_tab_flat),
    .last_idx     (last_idx_q[DW-1:0]),
    .m_tdi        (m_tdi),
    .dev_tdo      (dev_tdo),
    .dev_tdi      (dev_tdi),
    .m_tdo        (m_tdo)
  );

endmodule

// File: tb/tb_jtag_chain_router.sv
// Directed bench for jtag_chain_router with 8 nodes and a 16-cycle WAIT timeout.
module tb_jtag_chain_router;

  localparam int N_NODE = 8;
  localparam int IW     = 4;
  localparam logic [3:0] FI = 4'd8;
  localparam logic [3:0] LI = 4'd9;
  localparam logic [3:0] NI = 4'd10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enb;
  logic [N_NODE-1:0]    active_chains;
  logic [N_NODE-1:0]    node_done;
  logic [N_NODE*IW-1:0] tdi_index_flat;
  logic [N_NODE*IW-1:0] tdo_index_flat;
  logic                 m_tdi;
  logic                 m_tdo;
  logic [N_NODE-1:0]    dev_tdo;
  logic [N_NODE-1:0]    dev_tdi;
  logic                 route_valid;
  logic                 route_error;
  logic [2:0]           err_code;
  logic [IW:0]          chain_len;
  logic [IW-1:0]        first_idx;
  logic [IW-1:0]        last_idx;

  logic [3:0] tdi_t [N_NODE];
  logic [3:0] tdo_t [N_NODE];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_chain_router #(
    .N_NODE  (N_NODE),
    .IW      (IW),
    .TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enb            (enb),
    .active_chains  (active_chains),
    .node_done      (node_done),
    .tdi_index_flat (tdi_index_flat),
    .tdo_index_flat (tdo_index_flat),
    .m_tdi          (m_tdi),
    .m_tdo          (m_tdo),
    .dev_tdo        (dev_tdo),
    .dev_tdi        (dev_tdi),
    .route_valid    (route_valid),
    .route_error    (route_error),
    .err_code       (err_code),
    .chain_len      (chain_len),
    .first_idx      (first_idx),
    .last_idx       (last_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < N_NODE; i++) begin
      tdi_index_flat[i*IW +: IW] = tdi_t[i];
      tdo_index_flat[i*IW +: IW] = tdo_t[i];
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < N_NODE; i++) begin
      tdi_t[i] = NI;
      tdo_t[i] = NI;
    end
  endtask

  // Chain 0 -> 2 -> 3 -> 5.
  task automatic set_nominal();
    clear_tables();
    tdi_t[0] = FI;   tdo_t[0] = 4'd2;
    tdi_t[2] = 4'd0; tdo_t[2] = 4'd3;
    tdi_t[3] = 4'd2; tdo_t[3] = 4'd5;
    tdi_t[5] = 4'd3; tdo_t[5] = LI;
    active_chains = 8'b0010_1101;
    pack();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(route_valid || route_error) && n < 40) begin
      tick();
      n++;
    end
    check("wait_bound", {31'd0, route_valid | route_error}, 32'd1);
  endtask

  // Starts from IDLE with node_done low; checks the N_NODE+2 edge latency.
  task automatic run_nominal(input string tag);
    set_nominal();
    node_done = '0;
    enb = 1'b1;
    tick();
    node_done = '1;
    repeat (9) tick();
    check({tag, "_lat_pre"}, {31'd0, route_valid}, 32'd0);
    tick();
    check({tag, "_lat"}, {31'd0, route_valid}, 32'd1);
    check({tag, "_len"}, chain_len, 32'd4);
    check({tag, "_first"}, first_idx, 32'd0);
    check({tag, "_last"}, last_idx, 32'd5);
    check({tag, "_err"}, {29'd0, err_code}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    enb = 1'b0;
    active_chains = '0;
    node_done = '0;
    m_tdi = 1'b0;
    dev_tdo = '0;
    clear_tables();
    pack();
    tick();
    tick();
    check("rst_valid", {31'd0, route_valid}, 32'd0);
    check("rst_error", {31'd0, route_error}, 32'd0);
    check("rst_dev_tdi", dev_tdi, 32'hFF);
    check("rst_m_tdo", {31'd0, m_tdo}, 32'd1);
    check("rst_len", chain_len, 32'd0);
    rst_n = 1'b1;
    tick();

    // Nominal chain and data path.
    run_nominal("nom");
    m_tdi = 1'b0; dev_tdo = 8'h01; #1;
    check("dp1_dev_tdi", dev_tdi, 32'hD6);
    check("dp1_m_tdo", {31'd0, m_tdo}, 32'd0);
    m_tdi = 1'b1; dev_tdo = 8'h2C; #1;
    check("dp2_dev_tdi", dev_tdi, 32'hFB);
    check("dp2_m_tdo", {31'd0, m_tdo}, 32'd1);
    m_tdi = 1'b0; dev_tdo = 8'h08; #1;
    check("dp3_dev_tdi", dev_tdi, 32'hF2);
    check("dp3_m_tdo", {31'd0, m_tdo}, 32'd0);

    // Runtime change of the active vector.
    active_chains[6] = 1'b1;
    tick();
    check("chg_valid", {31'd0, route_valid}, 32'd0);
    check("chg_error", {31'd0, route_error}, 32'd1);
    check("chg_code", {29'd0, err_code}, 32'd5);
    check("chg_dev_tdi", dev_tdi, 32'hFF);
    enb = 1'b0;
    tick();

    // Inconsistent back-link on node 2.
    set_nominal();
    tdo_t[2] = 4'd5;
    pack();
    node_done = '1;
    enb = 1'b1;
    wait_done();
    check("link_error", {31'd0, route_error}, 32'd1);
    check("link_code", {29'd0, err_code}, 32'd2);
    check("link_dev_tdi", dev_tdi, 32'hFF);
    check("link_m_tdo", {31'd0, m_tdo}, 32'd1);
    enb = 1'b0;
    tick();
    check("link_clr_code", {29'd0, err_code}, 32'd0);
    check("link_clr_error", {31'd0, route_error}, 32'd0);

    // Timeout: node 7 never finishes.
    set_nominal();
    node_done = 8'h7F;
    enb = 1'b1;
    tick();
    repeat (15) tick();
    check("tmo_pre", {31'd0, route_error}, 32'd0);
    tick();
    check("tmo_error", {31'd0, route_error}, 32'd1);
    check("tmo_code", {29'd0, err_code}, 32'd1);
    enb = 1'b0;
    tick();

    // Empty chain.
    clear_tables();
    pack();
    active_chains = '0;
    node_done = '1;
    enb = 1'b1;
    wait_done();
    check("empty_code", {29'd0, err_code}, 32'd4);
    enb = 1'b0;
    tick();

    // Single-node chain.
    clear_tables();
    tdi_t[0] = FI;
    tdo_t[0] = LI;
    pack();
    active_chains = 8'h01;
    enb = 1'b1;
    wait_done();
    check("one_valid", {31'd0, route_valid}, 32'd1);
    check("one_len", chain_len, 32'd1);
    check("one_last", last_idx, 32'd0);
    m_tdi = 1'b0; dev_tdo = 8'h01; #1;
    check("one_m_tdo_hi", {31'd0, m_tdo}, 32'd1);
    check("one_dev_tdi", dev_tdi, 32'hFE);
    m_tdi = 1'b1; dev_tdo = 8'h00; #1;
    check("one_m_tdo_lo", {31'd0, m_tdo}, 32'd0);
    enb = 1'b0;
    tick();
    check("one_idle_valid", {31'd0, route_valid}, 32'd0);
    check("one_idle_len", chain_len, 32'd1);

    // Reset in the middle of CHECK, then a clean re-run.
    set_nominal();
    node_done = '0;
    enb = 1'b1;
    tick();
    node_done = '1;
    tick();
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, route_valid}, 32'd0);
    check("mid_rst_dev_tdi", dev_tdi, 32'hFF);
    check("mid_rst_len", chain_len, 32'd0);
    enb = 1'b0;
    node_done = '0;
    tick();
    rst_n = 1'b1;
    tick();
    run_nominal("rerun");
    m_tdi = 1'b1; dev_tdo = 8'h2C; #1;
    check("rerun_dev_tdi", dev_tdi, 32'hFB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
